magnitude_builder: RTL and testbench

MAGNITUDE_BUILDER -- requirements
Module: magnitude_builder

---
 rtl/magnitude_pkg.sv | 17 +
 rtl/magnitude_builder_if.sv | 28 ++
 rtl/mag_approx.sv | 67 ++++++
 rtl/magnitude_builder.sv | 133 +++++++++++++
 tb/tb_magnitude_builder.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/magnitude_pkg.sv
// Shared constants and state type for the FFT magnitude bank builder.
package magnitude_pkg;

  localparam int MAG_WIDTH = 9;
  localparam int MAG_MAX   = 511;

  localparam int DEF_N          = 1024;
  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_MAG_SHIFT  = 14;

  typedef enum logic [1:0] {
    FILL,
    DRAIN,
    WAIT_SWAP
  } state_t;

endpackage

// File: rtl/magnitude_builder_if.sv
// FFT bin stream into the magnitude builder: valid/ready with frame marker.
interface magnitude_builder_if #(
  parameter int DATA_WIDTH = 24
) ();

  logic                         fft_valid;
  logic signed [DATA_WIDTH-1:0] fft_re;
  logic signed [DATA_WIDTH-1:0] fft_im;
  logic                         fft_last;
  logic                         fft_ready;

  modport master (
    output fft_valid,
    output fft_re,
    output fft_im,
    output fft_last,
    input  fft_ready
  );

  modport slave (
    input  fft_valid,
    input  fft_re,
    input  fft_im,
    input  fft_last,
    output fft_ready
  );

endinterface

// File: rtl/mag_approx.sv
// Two-stage alpha-max-beta-min magnitude: abs, then combine/shift/saturate.
module mag_approx
  import magnitude_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAG_SHIFT  = DEF_MAG_SHIFT,
  parameter int IDX_WIDTH  = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_re,
  input  logic signed [DATA_WIDTH-1:0] in_im,
  input  logic [IDX_WIDTH-1:0]         in_idx,
  output logic                         mid_valid,
  output logic                         out_valid,
  output logic [MAG_WIDTH-1:0]         out_mag,
  output logic [IDX_WIDTH-1:0]         out_idx
);

  logic [DATA_WIDTH-1:0] abs_re;
  logic [DATA_WIDTH-1:0] abs_im;
  logic [DATA_WIDTH-1:0] s1_re;
  logic [DATA_WIDTH-1:0] s1_im;
  logic [IDX_WIDTH-1:0]  s1_idx;

  logic [DATA_WIDTH-1:0] mx;
  logic [DATA_WIDTH-1:0] mn;
  logic [DATA_WIDTH:0]   mag;
  logic [DATA_WIDTH:0]   shifted;
  logic [MAG_WIDTH-1:0]  sat;

  // Negating the most negative value wraps to 2^(W-1), exact as unsigned.
  assign abs_re = in_re[DATA_WIDTH-1] ? $unsigned(-in_re) : $unsigned(in_re);
  assign abs_im = in_im[DATA_WIDTH-1] ? $unsigned(-in_im) : $unsigned(in_im);

  always_comb begin
    mx      = (s1_re >= s1_im) ? s1_re : s1_im;
    mn      = (s1_re >= s1_im) ? s1_im : s1_re;
    mag     = {1'b0, mx} + ({1'b0, mn} >> 1);
    shifted = mag >> MAG_SHIFT;
    sat     = (|shifted[DATA_WIDTH:MAG_WIDTH])
            ? MAG_WIDTH'(MAG_MAX)
            : shifted[MAG_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mid_valid <= 1'b0;
      s1_re     <= '0;
      s1_im     <= '0;
      s1_idx    <= '0;
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_idx   <= '0;
    end else begin
      mid_valid <= in_valid;
      s1_re     <= abs_re;
      s1_im     <= abs_im;
      s1_idx    <= in_idx;
      out_valid <= mid_valid;
      out_mag   <= sat;
      out_idx   <= s1_idx;
    end
  end

endmodule

// File: rtl/magnitude_builder.sv
// Double-buffered FFT magnitude banks; MAG_PEAK_HOLD_EN enables decaying peak hold.
module magnitude_builder
  import magnitude_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAG_SHIFT  = DEF_MAG_SHIFT
) (
  input  logic                 clk,
  input  logic                 reset,
  magnitude_builder_if.slave   fft,
  input  logic                 draw_done,
  output logic [MAG_WIDTH-1:0] curr_magnitude_buffer [N/2],
  output logic                 process_done
);

  localparam int IW = $clog2(N);
  localparam int AW = IW - 1;

  state_t state;
  state_t state_nx;

  logic          accept;
  logic          swap;
  logic [IW-1:0] bin_cnt;
  logic          bank_sel;

  logic                 mid_valid;
  logic                 out_valid;
  logic [MAG_WIDTH-1:0] out_mag;
  logic [IW-1:0]        out_idx;

  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [MAG_WIDTH-1:0] wr_data;

  logic [MAG_WIDTH-1:0] bank [2][N/2];

  assign fft.fft_ready = (state == FILL);
  assign accept        = fft.fft_valid && (state == FILL);

  mag_approx #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAG_SHIFT  (MAG_SHIFT),
    .IDX_WIDTH  (IW)
  ) u_mag (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (accept),
    .in_re     (fft.fft_re),
    .in_im     (fft.fft_im),
    .in_idx    (bin_cnt),
    .mid_valid (mid_valid),
    .out_valid (out_valid),
    .out_mag   (out_mag),
    .out_idx   (out_idx)
  );

  // Upper half of the spectrum flows through the pipe but is never stored.
  assign wr_en   = out_valid && !out_idx[IW-1];
  assign wr_addr = out_idx[AW-1:0];

`ifdef MAG_PEAK_HOLD_EN
  logic [MAG_WIDTH-1:0] old_val;
  logic [MAG_WIDTH-1:0] decayed;

  always_comb begin
    old_val = bank[bank_sel][wr_addr];
    decayed = (old_val == '0) ? '0 : old_val - 1'b1;
    wr_data = (out_mag > decayed) ? out_mag : decayed;
  end
`else
  assign wr_data = out_mag;
`endif

  always_comb begin
    state_nx = state;
    swap     = 1'b0;
    unique case (state)
      FILL: begin
        if (fft.fft_valid && fft.fft_last)
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (!mid_valid)
          state_nx = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        if (draw_done) begin
          swap     = 1'b1;
          state_nx = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= FILL;
      bin_cnt      <= '0;
      bank_sel     <= 1'b0;
      process_done <= 1'b0;
    end else begin
      state        <= state_nx;
      bank_sel     <= bank_sel ^ swap;
      process_done <= swap;
      if (accept) begin
        if (fft.fft_last)
          bin_cnt <= '0;
        else if (bin_cnt != IW'(N - 1))
          bin_cnt <= bin_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N/2; i++) begin
        bank[0][i] <= '0;
        bank[1][i] <= '0;
      end
    end else if (wr_en) begin
      bank[!bank_sel][wr_addr] <= wr_data;
    end
  end

  always_comb begin
    for (int i = 0; i < N/2; i++)
      curr_magnitude_buffer[i] = bank[bank_sel][i];
  end

endmodule

// File: tb/tb_magnitude_builder.sv
// Self-checking bench for magnitude_builder: table vectors plus frame scoreboard.
module tb_magnitude_builder;

  localparam int N  = 1024;
  localparam int DW = 24;
  localparam int H  = N / 2;

  typedef struct {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    int                   exp;
  } vec_t;

  typedef struct {
    int         idx;
    logic [8:0] val;
  } sb_t;

  logic clk = 1'b0;
  logic reset;
  logic draw_done;
  logic process_done;
  logic [8:0] mag_buf [H];

  magnitude_builder_if #(.DATA_WIDTH(DW)) bus ();

  magnitude_builder #(
    .N          (N),
    .DATA_WIDTH (DW),
    .MAG_SHIFT  (14)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .fft                   (bus),
    .draw_done             (draw_done),
    .curr_magnitude_buffer (mag_buf),
    .process_done          (process_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  logic [8:0] model_bank [2][H];
  bit         m_sel;
  int         m_idx;
  sb_t        sbq[$];
  vec_t       tbl[9];

  always @(negedge clk)
    if (process_done === 1'b1) pulse_cnt++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] calc(logic signed [DW-1:0] re,
                                      logic signed [DW-1:0] im);
    longint a, b, mx, mn, m;
    a  = re; b = im;
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    m  = (mx + mn / 2) >>> 14;
    return (m > 511) ? 9'd511 : m[8:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < H; i++) begin
      model_bank[0][i] = '0;
      model_bank[1][i] = '0;
    end
    m_sel = 1'b0;
    m_idx = 0;
    sbq.delete();
  endtask

  task automatic model_accept(logic signed [DW-1:0] re,
                              logic signed [DW-1:0] im, bit last);
    logic [8:0] v;
    sb_t e;
    if (m_idx < H) begin
      v = calc(re, im);
`ifdef MAG_PEAK_HOLD_EN
      begin
        logic [8:0] d;
        d = (model_bank[m_sel][m_idx] == 0) ? 9'd0
          : model_bank[m_sel][m_idx] - 9'd1;
        if (d > v) v = d;
      end
`endif
      model_bank[!m_sel][m_idx] = v;
      e.idx = m_idx;
      e.val = v;
      sbq.push_back(e);
    end
    if (last) m_idx = 0;
    else if (m_idx != N - 1) m_idx++;
  endtask

  task automatic send_bin(logic signed [DW-1:0] re,
                          logic signed [DW-1:0] im, bit last);
    int g = 0;
    bus.fft_valid = 1'b1;
    bus.fft_re    = re;
    bus.fft_im    = im;
    bus.fft_last  = last;
    while (bus.fft_ready !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (bus.fft_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end else begin
      model_accept(re, im, last);
    end
    @(negedge clk);
    bus.fft_valid = 1'b0;
    bus.fft_last  = 1'b0;
  endtask

  task automatic chk_buf(string nm);
    int bad = -1;
    for (int i = 0; i < H; i++)
      if (bad < 0 && mag_buf[i] !== model_bank[m_sel][i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: entry %0d got %0d expected %0d",
               nm, bad, mag_buf[bad], model_bank[m_sel][bad]);
    end
  endtask

  task automatic swap_check(string nm);
    sb_t e;
    m_sel = !m_sel;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk(nm, mag_buf[e.idx], e.val);
    end
    chk_buf({nm, "_all"});
  endtask

  task automatic wait_swap(string nm);
    int g = 0;
    while (process_done !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk({nm, "_pulse"}, process_done, 1);
    if (process_done === 1'b1) begin
      swap_check(nm);
      @(negedge clk);
      chk({nm, "_pulse_end"}, process_done, 0);
    end
  endtask

  initial begin
    int p0;
    tbl[0] = '{24'sd49152,    -24'sd32768,   4};
    tbl[1] = '{-24'sd8388608, -24'sd8388608, 511};
    tbl[2] = '{24'sd0,        24'sd0,        0};
    tbl[3] = '{24'sd16383,    24'sd0,        0};
    tbl[4] = '{24'sd16384,    24'sd0,        1};
    tbl[5] = '{-24'sd16384,   24'sd16384,    1};
    tbl[6] = '{24'sd8388607,  24'sd0,        511};
    tbl[7] = '{24'sd32768,    24'sd32768,    3};
    tbl[8] = '{-24'sd8388608, 24'sd0,        511};

    reset         = 1'b0;
    draw_done     = 1'b1;
    bus.fft_valid = 1'b0;
    bus.fft_re    = '0;
    bus.fft_im    = '0;
    bus.fft_last  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    chk_buf("reset_buf");
    chk("reset_pd", process_done, 0);
    chk("reset_ready", bus.fft_ready, 1);

    // Full frame, draw_done already high; upper half ignored.
    for (int i = 0; i < N; i++)
      send_bin(24'(16384 * (i % 4)), '0, i == N - 1);
    wait_swap("frame_mod4");
    chk("mod4_e5", mag_buf[5], 1);
    chk("mod4_e511", mag_buf[511], 3);

    // Short frame of table vectors; untouched entries keep old contents.
    for (int i = 0; i < 9; i++)
      send_bin(tbl[i].re, tbl[i].im, i == 8);
    wait_swap("table");
`ifndef MAG_PEAK_HOLD_EN
    for (int i = 0; i < 9; i++)
      chk($sformatf("tbl_%0d", i), mag_buf[i], tbl[i].exp);
`endif

    // Hold draw_done low: no ready, no pulse until it rises.
    draw_done = 1'b0;
    for (int i = 0; i < 20; i++)
      send_bin(24'(16384 * (i + 2)), 24'(-8192 * i), i == 19);
    for (int c = 0; c < 50; c++) begin
      chk("hold_ready", bus.fft_ready, 0);
      chk("hold_pd", process_done, 0);
      @(negedge clk);
    end
    draw_done = 1'b1;
    @(negedge clk);
    chk("hold_pulse", process_done, 1);
    if (process_done === 1'b1) begin
      swap_check("hold");
      @(negedge clk);
      chk("hold_pulse_end", process_done, 0);
    end

    // Overrun: no fft_last until past N bins; counter saturates.
    for (int i = 0; i < N + 6; i++)
      send_bin(24'(16384 * ((i % 3) + 5)), 24'sd100, i == N + 5);
    wait_swap("overrun");

    // Reset mid-frame, then a fresh full frame.
    for (int i = 0; i < 300; i++)
      send_bin(24'(16384 * 9), '0, 1'b0);
    @(posedge clk);
    p0 = pulse_cnt;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_mid_pd", process_done, 0);
    chk("rst_mid_ready", bus.fft_ready, 1);
    chk_buf("rst_mid_buf");
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++)
      send_bin(24'(16384 * ((i % 6) + 1)), 24'sd16384, i == N - 1);
    wait_swap("post_reset");
    repeat (5) @(negedge clk);
    @(posedge clk);
    chk("post_reset_pulses", pulse_cnt - p0, 1);
    @(negedge clk);

`ifdef MAG_PEAK_HOLD_EN
    for (int i = 0; i < H; i++)
      send_bin(24'(16384 * 10), '0, i == H - 1);
    wait_swap("peak_tens");
    for (int i = 0; i < H; i++)
      send_bin('0, '0, i == H - 1);
    wait_swap("peak_zeros");
    for (int i = 0; i < H; i += 97)
      chk($sformatf("peak_%0d", i), mag_buf[i], 9);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
